core_ctrl: RTL and testbench
============================

CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 Parameter DIM, default 1023; hypervector MSB index, so vector width is DIM+1.
REQ-002 Parameter FIFO_DEPTH, default 4; result FIFO entries, power of two, at least 2.
REQ-003 clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle job request; acted on only in IDLE.
REQ-006 item_num  in  16  number of item vectors to load; 0 means skip loading.
REQ-007 rand_valid / rand_ready  in / out  1 / 1  random-vector handshake.
REQ-008 rand_data  in  DIM+1  random vector, passed straight to the core.
REQ-009 s_inst_valid / s_inst_ready  in / out  1 / 1  instruction-word handshake.
REQ-010 s_inst_data  in  32  instruction word: [31:16] opcode one-hot, [15:0] item address.
REQ-011 core_run, core_gen, core_update_item, core_get_v, core_exec  out  1 each  core controls.
REQ-012 core_item_a, core_item_memory_num  out  16 each  item write address; item count.
REQ-013 core_get_d  out  32  instruction word to the core.
REQ-014 core_store, core_last  in  1 each; core_result  in  DIM+1  core outputs.
REQ-015 m_valid / m_ready  out / in  1 / 1  result-stream handshake.
REQ-016 m_data  out  DIM+1; m_last  out  1  result vector; final-result flag.
REQ-017 busy, done  out  1 each  job active; one-cycle job-complete pulse.

Function
REQ-018 The FSM SHALL have states IDLE, GEN, EXEC, WAIT_LAST, DRAIN and DONE.
REQ-019 IDLE: core_run=0, busy=0; start moves to GEN, or to EXEC if item_num==0.
REQ-020 IDLE latches item_num on start; core_item_memory_num SHALL equal the latched value.
REQ-021 GEN SHALL drive core_gen=1 and rand_ready=1, with core_item_a starting at 0.
REQ-022 In GEN, each cycle with rand_valid=1 SHALL assert core_update_item=1 for that cycle only, then increment core_item_a.
REQ-023 GEN SHALL move to EXEC in the cycle after the write at item_a == item_num-1.
REQ-024 EXEC, WAIT_LAST and DRAIN SHALL hold core_run=1 and core_exec=1; no other state asserts them.
REQ-025 EXEC: s_inst_ready = (fifo_count + inflight < FIFO_DEPTH).
REQ-026 EXEC: core_get_v = s_inst_valid & s_inst_ready, and core_get_d = s_inst_data (combinational).
REQ-027 inflight counts accepted words whose result slot is not yet resolved: +1 on each accept, -1 two cycles later.
REQ-028 A result SHALL be pushed when core_store=1 and core_get_v was 1 two cycles earlier.
REQ-029 A held-high core_store SHALL NOT be pushed twice.
REQ-030 An accepted word with opcode bit 7 set SHALL move EXEC to WAIT_LAST; core_get_v=0 from the next cycle.
REQ-031 WAIT_LAST: the first cycle with core_last=1 SHALL push core_result with m_last=1, then move to DRAIN.
REQ-032 DRAIN SHALL move to DONE once the FIFO is empty.
REQ-033 DONE: done=1 for one cycle, core_run=0 (clears the core's registers), then IDLE.
REQ-034 The FIFO SHALL never overflow; a push and a pop in the same cycle keep the count unchanged.
REQ-035 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-036 m_data and m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-037 start outside IDLE SHALL be ignored.
REQ-038 busy SHALL be 1 in every state except IDLE.

Reset
REQ-039 rst=1 SHALL force IDLE asynchronously and clear FIFO, pointers, inflight and item_a.
REQ-040 During rst, all outputs SHALL be 0: core_* controls, rand_ready, s_inst_ready, m_valid, m_last, busy, done.
REQ-041 rst mid-job SHALL discard all buffered results; the next start begins a fresh job.

Structure
REQ-042 Package core_pkg SHALL hold: FSM state enum, opcode bit constants (LOAD=0 ... LAST_STORE=7), ITEM_AW=16.
REQ-043 The result FIFO SHALL be one sub-module, core_res_fifo, parameterised by width and depth.

Verification
REQ-044 item_num=3 with rand_valid held high -> three update_item pulses at item_a 0,1,2, then EXEC.
REQ-045 item_num=0 and start -> EXEC the next cycle, with no core_gen.
REQ-046 Words 0x0001_0002, 0x0020_0000, 0x0080_0000 with m_ready=1 -> one store result, then one result with m_last=1, then a done pulse.
REQ-047 m_ready=0 with 6 store words offered -> s_inst_ready drops after 4 accepts; data held stable; drains in order once m_ready=1.
REQ-048 rst pulsed in GEN and in EXEC with 2 results buffered -> m_valid=0 and busy=0 immediately; a later job runs clean.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the hypervector core controller: FSM states,
// instruction opcode bit positions and the item address width.
package core_pkg;

    localparam int ITEM_AW = 16;
    localparam int INST_W  = 32;
    localparam int OP_LSB  = 16;

    localparam int unsigned OP_LOAD       = 0;
    localparam int unsigned OP_BIND       = 1;
    localparam int unsigned OP_BUNDLE     = 2;
    localparam int unsigned OP_PERMUTE    = 3;
    localparam int unsigned OP_SIMILARITY = 4;
    localparam int unsigned OP_STORE      = 5;
    localparam int unsigned OP_CLEAR      = 6;
    localparam int unsigned OP_LAST_STORE = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN,
        ST_EXEC,
        ST_WAIT_LAST,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic logic op_bit(input logic [INST_W-1:0] word, input int unsigned op);
        return word[OP_LSB + op];
    endfunction

endpackage

// File: rtl/core_ctrl_if.sv
// Bundle of job, random-vector, instruction, core and result-stream signals
// between the controller (master) and its surroundings (slave).
interface core_ctrl_if #(
    parameter int DIM = 1023
);
    import core_pkg::*;

    logic                start;
    logic [ITEM_AW-1:0]  item_num;
    logic                rand_valid;
    logic                rand_ready;
    logic [DIM:0]        rand_data;
    logic                s_inst_valid;
    logic                s_inst_ready;
    logic [INST_W-1:0]   s_inst_data;
    logic                core_run;
    logic                core_gen;
    logic                core_update_item;
    logic                core_get_v;
    logic                core_exec;
    logic [ITEM_AW-1:0]  core_item_a;
    logic [ITEM_AW-1:0]  core_item_memory_num;
    logic [INST_W-1:0]   core_get_d;
    logic                core_store;
    logic                core_last;
    logic [DIM:0]        core_result;
    logic                m_valid;
    logic                m_ready;
    logic [DIM:0]        m_data;
    logic                m_last;
    logic                busy;
    logic                done;

    // rand_data goes straight from the source to the core; the controller only handshakes it.
    modport master (
        input  start, item_num, rand_valid, s_inst_valid, s_inst_data,
               core_store, core_last, core_result, m_ready,
        output rand_ready, s_inst_ready, core_run, core_gen, core_update_item,
               core_get_v, core_exec, core_item_a, core_item_memory_num,
               core_get_d, m_valid, m_data, m_last, busy, done
    );

    modport slave (
        output start, item_num, rand_valid, rand_data, s_inst_valid, s_inst_data,
               core_store, core_last, core_result, m_ready,
        input  rand_ready, s_inst_ready, core_run, core_gen, core_update_item,
               core_get_v, core_exec, core_item_a, core_item_memory_num,
               core_get_d, m_valid, m_data, m_last, busy, done
    );

endinterface

// File: rtl/core_res_fifo.sv
// Result FIFO: power-of-two depth, wrapping pointers, first-word-fall-through read.
module core_res_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/core_ctrl.sv
// Job controller for the hypervector core: item generation, instruction issue
// with result-slot credit tracking, and in-order buffering of results.
module core_ctrl
    import core_pkg::*;
#(
    parameter int DIM        = 1023,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    core_ctrl_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t             state;
    state_t             state_nxt;
    logic [ITEM_AW-1:0] item_a;
    logic [ITEM_AW-1:0] item_num_q;
    logic [CW-1:0]      inflight;
    logic [CW-1:0]      fifo_count;
    logic               gv_d1;
    logic               gv_d2;
    logic               run_q;
    logic               gen_q;
    logic               exec_q;
    logic               busy_q;
    logic               done_q;
    logic               accept;
    logic               last_accept;
    logic               store_push;
    logic               last_push;
    logic               fifo_full;
    logic               fifo_empty;
    logic [DIM+1:0]     pop_data;

    // Credits cover both buffered results and words whose result is still in the core pipe.
    assign bus.s_inst_ready = (state == ST_EXEC) &&
                              (({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH));
    assign accept           = bus.s_inst_valid & bus.s_inst_ready;
    assign last_accept      = accept & op_bit(bus.s_inst_data, OP_LAST_STORE);

    assign bus.core_get_v           = accept;
    assign bus.core_get_d           = bus.s_inst_data;
    assign bus.core_run             = run_q;
    assign bus.core_exec            = exec_q;
    assign bus.core_gen             = gen_q;
    assign bus.rand_ready           = gen_q;
    assign bus.core_update_item     = gen_q & bus.rand_valid;
    assign bus.core_item_a          = item_a;
    assign bus.core_item_memory_num = item_num_q;
    assign bus.busy                 = busy_q;
    assign bus.done                 = done_q;

    // A store only counts in the slot of the word that produced it, so a held-high store is pushed once.
    assign store_push = bus.core_store & gv_d2;
    assign last_push  = (state == ST_WAIT_LAST) & bus.core_last & ~store_push & ~fifo_full;

    assign bus.m_valid = ~fifo_empty;
    assign bus.m_last  = ~fifo_empty & pop_data[DIM+1];
    assign bus.m_data  = fifo_empty ? '0 : pop_data[DIM:0];

    core_res_fifo #(
        .WIDTH (DIM + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (store_push | last_push),
        .wdata ({last_push, bus.core_result}),
        .pop   (bus.m_valid & bus.m_ready),
        .rdata (pop_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (bus.start) state_nxt = (bus.item_num == '0) ? ST_EXEC : ST_GEN;
            ST_GEN:       if (bus.rand_valid && item_a == item_num_q - ITEM_AW'(1)) state_nxt = ST_EXEC;
            ST_EXEC:      if (last_accept) state_nxt = ST_WAIT_LAST;
            ST_WAIT_LAST: if (last_push) state_nxt = ST_DRAIN;
            ST_DRAIN:     if (fifo_empty && inflight == '0) state_nxt = ST_DONE;
            ST_DONE:      state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            item_a     <= '0;
            item_num_q <= '0;
            inflight   <= '0;
            gv_d1      <= 1'b0;
            gv_d2      <= 1'b0;
            run_q      <= 1'b0;
            gen_q      <= 1'b0;
            exec_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state  <= state_nxt;
            run_q  <= state_nxt inside {ST_EXEC, ST_WAIT_LAST, ST_DRAIN};
            exec_q <= state_nxt inside {ST_EXEC, ST_WAIT_LAST, ST_DRAIN};
            gen_q  <= (state_nxt == ST_GEN);
            busy_q <= (state_nxt != ST_IDLE);
            done_q <= (state_nxt == ST_DONE);

            if (state == ST_IDLE && bus.start) begin
                item_num_q <= bus.item_num;
                item_a     <= '0;
            end else if (state == ST_GEN && bus.rand_valid) begin
                item_a <= item_a + ITEM_AW'(1);
            end

            gv_d1    <= accept;
            gv_d2    <= gv_d1;
            inflight <= inflight + CW'(accept) - CW'(gv_d2);
        end
    end

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl: a table-driven full job plus hand-written
// sequences for skip-load, backpressure, held store and mid-job reset.
module tb_core_ctrl;

    localparam int DIM = 63;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    core_ctrl_if #(.DIM(DIM)) bus();

    core_ctrl #(
        .DIM        (DIM),
        .FIFO_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural core: result appears two cycles after an issued word.
    logic        p1v = 1'b0;
    logic        p2v = 1'b0;
    logic [31:0] p1d = '0;
    logic [31:0] p2d = '0;
    logic        store_hold;

    always @(posedge clk) begin
        p1v <= bus.core_get_v;
        p1d <= bus.core_get_d;
        p2v <= p1v;
        p2d <= p1d;
    end

    assign bus.core_store  = (p2v & p2d[21]) | store_hold;
    assign bus.core_last   = p2v & p2d[23];
    assign bus.core_result = {~p2d, p2d};

    logic [10:0] ctrl;
    assign ctrl = {bus.core_run, bus.core_gen, bus.core_update_item, bus.core_get_v,
                   bus.core_exec, bus.rand_ready, bus.s_inst_ready, bus.m_valid,
                   bus.m_last, bus.busy, bus.done};

    logic [32:0] popq[$];
    always @(negedge clk) begin
        if (bus.m_valid && bus.m_ready) popq.push_back({bus.m_last, bus.m_data[31:0]});
    end

    typedef struct {
        logic        start;
        logic [15:0] num;
        logic        rv;
        logic        iv;
        logic [31:0] idata;
        logic [10:0] ctrl;
        logic [15:0] ia;
        logic [15:0] mn;
        logic        chk;
        logic [31:0] md;
    } vec_t;

    vec_t vt[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [15:0] n);
        bus.start    = 1'b1;
        bus.item_num = n;
        cyc();
        bus.start    = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic got;
        got = 1'b0;
        bus.s_inst_valid = 1'b1;
        bus.s_inst_data  = w;
        for (int i = 0; i < 30 && !got; i++) begin
            #1;
            if (bus.s_inst_ready) got = 1'b1;
            cyc();
        end
        bus.s_inst_valid = 1'b0;
        check("send_word", 64'(got), 64'd1);
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            #1;
            if (bus.done) seen = 1'b1;
            cyc();
        end
        check(name, 64'(seen), 64'd1);
    endtask

    initial begin
        int base;
        int k;

        rst              = 1'b1;
        store_hold       = 1'b0;
        bus.start        = 1'b1;
        bus.item_num     = 16'd7;
        bus.rand_valid   = 1'b1;
        bus.rand_data    = 64'hC0FF_EE00_1234_5678;
        bus.s_inst_valid = 1'b1;
        bus.s_inst_data  = 32'h0080_0000;
        bus.m_ready      = 1'b1;
        cyc();
        #1;
        check("reset_ctrl", 64'(ctrl), 64'd0);
        check("reset_item_a", 64'(bus.core_item_a), 64'd0);
        check("reset_mem_num", 64'(bus.core_item_memory_num), 64'd0);
        bus.start        = 1'b0;
        bus.rand_valid   = 1'b0;
        bus.s_inst_valid = 1'b0;
        cyc();
        rst = 1'b0;

        // Full job: three generated items, then load, store and last-store words.
        vt[0]  = '{1'b1, 16'd3, 1'b1, 1'b0, 32'h0,         11'b00000000000, 16'd0, 16'd0, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 16'd3, 1'b1, 1'b0, 32'h0,         11'b01100100010, 16'd0, 16'd3, 1'b0, 32'h0};
        vt[2]  = '{1'b0, 16'd3, 1'b1, 1'b0, 32'h0,         11'b01100100010, 16'd1, 16'd3, 1'b0, 32'h0};
        vt[3]  = '{1'b0, 16'd3, 1'b1, 1'b0, 32'h0,         11'b01100100010, 16'd2, 16'd3, 1'b0, 32'h0};
        vt[4]  = '{1'b0, 16'd3, 1'b1, 1'b1, 32'h0001_0002, 11'b10011010010, 16'd3, 16'd3, 1'b0, 32'h0};
        vt[5]  = '{1'b1, 16'd9, 1'b0, 1'b1, 32'h0020_0000, 11'b10011010010, 16'd3, 16'd3, 1'b0, 32'h0};
        vt[6]  = '{1'b0, 16'd9, 1'b0, 1'b1, 32'h0080_0000, 11'b10011010010, 16'd3, 16'd3, 1'b0, 32'h0};
        vt[7]  = '{1'b0, 16'd9, 1'b0, 1'b0, 32'h0,         11'b10001000010, 16'd3, 16'd3, 1'b0, 32'h0};
        vt[8]  = '{1'b0, 16'd9, 1'b0, 1'b0, 32'h0,         11'b10001001010, 16'd3, 16'd3, 1'b1, 32'h0020_0000};
        vt[9]  = '{1'b0, 16'd9, 1'b0, 1'b0, 32'h0,         11'b10001001110, 16'd3, 16'd3, 1'b1, 32'h0080_0000};
        vt[10] = '{1'b0, 16'd9, 1'b0, 1'b0, 32'h0,         11'b10001000010, 16'd3, 16'd3, 1'b0, 32'h0};
        vt[11] = '{1'b0, 16'd9, 1'b0, 1'b0, 32'h0,         11'b00000000011, 16'd3, 16'd3, 1'b0, 32'h0};
        vt[12] = '{1'b0, 16'd9, 1'b0, 1'b0, 32'h0,         11'b00000000000, 16'd3, 16'd3, 1'b0, 32'h0};

        for (int i = 0; i < 13; i++) begin
            bus.start        = vt[i].start;
            bus.item_num     = vt[i].num;
            bus.rand_valid   = vt[i].rv;
            bus.s_inst_valid = vt[i].iv;
            bus.s_inst_data  = vt[i].idata;
            #1;
            check($sformatf("row%0d_ctrl", i), 64'(ctrl), 64'(vt[i].ctrl));
            check($sformatf("row%0d_item_a", i), 64'(bus.core_item_a), 64'(vt[i].ia));
            check($sformatf("row%0d_mem_num", i), 64'(bus.core_item_memory_num), 64'(vt[i].mn));
            if (vt[i].chk) check($sformatf("row%0d_m_data", i), 64'(bus.m_data[31:0]), 64'(vt[i].md));
            cyc();
        end
        bus.start        = 1'b0;
        bus.s_inst_valid = 1'b0;

        // item_num == 0: straight to EXEC, no generation.
        base = popq.size();
        start_job(16'd0);
        #1;
        check("skip_gen_ctrl", 64'(ctrl), 64'b10001010010);
        cyc();
        send_word(32'h0080_0000);
        wait_done("skip_gen_done");
        check("skip_gen_pops", 64'(popq.size() - base), 64'd1);
        if (popq.size() - base >= 1) check("skip_gen_last", 64'(popq[base]), {31'd0, 1'b1, 32'h0080_0000});

        // Held-high core_store with no issued words must not push.
        base = popq.size();
        start_job(16'd0);
        store_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("held_store_c%0d", i), 64'(bus.m_valid), 64'd0);
            cyc();
        end
        store_hold = 1'b0;
        cyc();
        cyc();
        send_word(32'h0080_0000);
        wait_done("held_store_done");
        check("held_store_pops", 64'(popq.size() - base), 64'd1);

        // Backpressure: six store words with m_ready low, only four credits.
        base = popq.size();
        bus.m_ready = 1'b0;
        start_job(16'd0);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            bus.s_inst_valid = (k < 6);
            bus.s_inst_data  = 32'h0020_0000 | 32'(k);
            #1;
            if (bus.s_inst_valid && bus.s_inst_ready) k++;
            cyc();
        end
        #1;
        check("bp_accepts", 64'(k), 64'd4);
        check("bp_ready_low", 64'(bus.s_inst_ready), 64'd0);
        check("bp_m_valid", 64'(bus.m_valid), 64'd1);
        check("bp_data_a", 64'(bus.m_data[31:0]), 64'h0020_0000);
        cyc();
        cyc();
        cyc();
        #1;
        check("bp_data_b", 64'(bus.m_data[31:0]), 64'h0020_0000);
        check("bp_last_b", 64'(bus.m_last), 64'd0);
        cyc();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 40 && (popq.size() - base) < 6; i++) begin
            bus.s_inst_valid = (k < 6);
            bus.s_inst_data  = 32'h0020_0000 | 32'(k);
            #1;
            if (bus.s_inst_valid && bus.s_inst_ready) k++;
            cyc();
        end
        bus.s_inst_valid = 1'b0;
        check("bp_pop_count", 64'(popq.size() - base), 64'd6);
        for (int i = 0; i < 6 && base + i < popq.size(); i++)
            check($sformatf("bp_pop%0d", i), 64'(popq[base + i]), {31'd0, 1'b0, 32'h0020_0000 | 32'(i)});
        send_word(32'h0080_0000);
        wait_done("bp_done");

        // Reset during GEN.
        bus.rand_valid = 1'b1;
        start_job(16'd5);
        cyc();
        rst = 1'b1;
        #1;
        check("rst_gen_ctrl", 64'(ctrl), 64'd0);
        check("rst_gen_item_a", 64'(bus.core_item_a), 64'd0);
        bus.rand_valid = 1'b0;
        cyc();
        rst = 1'b0;

        // Reset during EXEC with two results buffered.
        bus.m_ready = 1'b0;
        start_job(16'd0);
        send_word(32'h0020_0011);
        send_word(32'h0020_0022);
        cyc();
        cyc();
        cyc();
        #1;
        check("rst_exec_buffered", 64'(bus.m_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_exec_ctrl", 64'(ctrl), 64'd0);
        cyc();
        rst = 1'b0;
        cyc();

        // A fresh job after reset sees none of the discarded results.
        base = popq.size();
        bus.m_ready = 1'b1;
        start_job(16'd0);
        send_word(32'h0020_0077);
        send_word(32'h0080_0000);
        wait_done("fresh_done");
        check("fresh_pops", 64'(popq.size() - base), 64'd2);
        if (popq.size() - base >= 2) begin
            check("fresh_first", 64'(popq[base]), {31'd0, 1'b0, 32'h0020_0077});
            check("fresh_last", 64'(popq[base + 1]), {31'd0, 1'b1, 32'h0080_0000});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
